// File: rtl/loader_pkg.sv
// loader_pkg: shared state encoding and default widths for the instruction memory loader.
package loader_pkg;
   localparam int LDR_ADDR_W = 8;
   localparam int LDR_DATA_W = 8;
   typedef enum logic [2:0] {
      S_LEN  = 3'd0,
      S_DATA = 3'd1,
      S_CHK  = 3'd2,
      S_HOLD = 3'd3,
      S_RUN  = 3'd4,
      S_ERR  = 3'd5
   } state_t;
endpackage

// File: rtl/imem_ram.sv
// imem_ram: 2**ADDR_W x DATA_W storage, synchronous write, asynchronous read.
module imem_ram #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 8
) (
   input  logic              i_clk,
   input  logic              i_we,
   input  logic [ADDR_W-1:0] i_waddr,
   input  logic [DATA_W-1:0] i_wdata,
   input  logic [ADDR_W-1:0] i_raddr,
   output logic [DATA_W-1:0] o_rdata
);
   logic [DATA_W-1:0] r_mem [2**ADDR_W];

   always_ff @(posedge i_clk)
      if (i_we) r_mem[i_waddr] <= i_wdata;

   assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/imem_loader.sv
// imem_loader: instruction memory with a length-prefixed byte-stream loader; holds the CPU in reset until loaded.
// Define LOADER_CHECKSUM_EN to require a trailing XOR checksum byte after the payload.
module imem_loader
   import loader_pkg::*;
#(
   parameter int ADDR_W      = LDR_ADDR_W,
   parameter int DATA_W      = LDR_DATA_W,
   parameter int HOLD_CYCLES = 4
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic [DATA_W-1:0] RX_DATA,
   input  logic              RX_VALID,
   output logic              RX_READY,
   input  logic              RELOAD,
   input  logic [ADDR_W-1:0] Read_Address,
   output logic [DATA_W-1:0] instruction,
   output logic              CPU_RST,
   output logic              LOADED,
   output logic              ERR,
   output logic [ADDR_W-1:0] LOAD_COUNT
);
   state_t            r_state, w_next;
   logic [ADDR_W-1:0] r_len, r_cnt;
   logic [7:0]        r_hold;
   logic              r_cpu_rst, r_loaded;
   logic              w_acc, w_last, w_we, w_in_range, w_reload;
   logic [DATA_W-1:0] w_rdata;

   assign RX_READY   = (r_state == S_LEN) || (r_state == S_DATA) || (r_state == S_CHK);
   assign w_acc      = RX_VALID && RX_READY;
   assign w_last     = r_cnt == r_len - ADDR_W'(1);
   assign w_we       = (r_state == S_DATA) && w_acc;
   assign w_reload   = RELOAD && ((r_state == S_RUN) || (r_state == S_ERR));
   // A zero length byte means the whole memory was loaded, so every address is valid.
   assign w_in_range = (r_len == '0) || (Read_Address < r_len);
   assign instruction = (r_loaded && w_in_range) ? w_rdata : '0;
   assign CPU_RST    = r_cpu_rst;
   assign LOADED     = r_loaded;
   assign LOAD_COUNT = r_cnt;

`ifdef LOADER_CHECKSUM_EN
   logic [DATA_W-1:0] r_xor;

   always_ff @(posedge CLK)
      if (!RST || r_state == S_LEN) r_xor <= '0;
      else if (w_we) r_xor <= r_xor ^ RX_DATA;

   assign ERR = r_state == S_ERR;
`else
   assign ERR = 1'b0;
`endif

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_LEN:  w_next = w_acc ? S_DATA : S_LEN;
`ifdef LOADER_CHECKSUM_EN
         S_DATA: w_next = (w_acc && w_last) ? S_CHK : S_DATA;
         S_CHK:  w_next = !w_acc ? S_CHK : (RX_DATA == r_xor) ? S_HOLD : S_ERR;
`else
         S_DATA: w_next = (w_acc && w_last) ? S_HOLD : S_DATA;
`endif
         S_HOLD: w_next = (r_hold == 8'(HOLD_CYCLES - 1)) ? S_RUN : S_HOLD;
         S_RUN:  w_next = RELOAD ? S_LEN : S_RUN;
         S_ERR:  w_next = RELOAD ? S_LEN : S_ERR;
         default: w_next = S_LEN;
      endcase
   end

   always_ff @(posedge CLK)
      if (!RST) begin
         r_state   <= S_LEN;
         r_len     <= '0;
         r_cnt     <= '0;
         r_hold    <= '0;
         r_cpu_rst <= 1'b1;
         r_loaded  <= 1'b0;
      end else begin
         r_state   <= w_next;
         r_cpu_rst <= w_next != S_RUN;
         r_loaded  <= w_next == S_RUN;
         r_hold    <= (r_state == S_HOLD) ? r_hold + 8'd1 : 8'd0;
         if (r_state == S_LEN && w_acc) begin
            r_len <= ADDR_W'(RX_DATA);
            r_cnt <= '0;
         end else if (w_we) begin
            r_cnt <= r_cnt + ADDR_W'(1);
         end else if (w_reload) begin
            r_cnt <= '0;
         end
      end

   imem_ram #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_ram (
      .i_clk  (CLK),
      .i_we   (w_we),
      .i_waddr(r_cnt),
      .i_wdata(RX_DATA),
      .i_raddr(Read_Address),
      .o_rdata(w_rdata)
   );
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed cycle table for the basic load/reload flow plus hand sequences for corner cases.
module tb_imem_loader;
   logic       CLK = 1'b0, RST = 1'b0, RX_VALID = 1'b0, RELOAD = 1'b0;
   logic [7:0] RX_DATA = '0, Read_Address = '0;
   logic       RX_READY, CPU_RST, LOADED, ERR;
   logic [7:0] instruction, LOAD_COUNT;
   int         n_vec = 0, n_err = 0;
   logic [7:0] cks;

   imem_loader dut (
      .CLK(CLK), .RST(RST), .RX_DATA(RX_DATA), .RX_VALID(RX_VALID), .RX_READY(RX_READY),
      .RELOAD(RELOAD), .Read_Address(Read_Address), .instruction(instruction),
      .CPU_RST(CPU_RST), .LOADED(LOADED), .ERR(ERR), .LOAD_COUNT(LOAD_COUNT)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      logic       rst_n, valid, reload;
      logic [7:0] data, addr;
      logic       e_rdy, e_cpu, e_ld;
      logic [7:0] e_cnt, e_ins;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(logic rst_n, logic valid, logic [7:0] data, logic reload, logic [7:0] addr,
                               logic e_rdy, logic e_cpu, logic e_ld, logic [7:0] e_cnt, logic [7:0] e_ins);
      return '{rst_n, valid, reload, data, addr, e_rdy, e_cpu, e_ld, e_cnt, e_ins};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic do_reset();
      RST = 1'b0; RX_VALID = 1'b0; RELOAD = 1'b0;
      tick();
      RST = 1'b1;
   endtask

   task automatic send_byte(input logic [7:0] d);
      RX_DATA = d; RX_VALID = 1'b1;
      tick();
      RX_VALID = 1'b0; RX_DATA = 8'hEE;
   endtask

   task automatic send_len(input logic [7:0] l);
      cks = '0;
      send_byte(l);
   endtask

   task automatic send_data(input logic [7:0] d);
      cks = cks ^ d;
      send_byte(d);
   endtask

   task automatic send_tail();
`ifdef LOADER_CHECKSUM_EN
      send_byte(cks);
`endif
   endtask

   task automatic wait_loaded(input string name);
      int i;
      i = 0;
      while (!LOADED && i < 40) begin
         tick();
         i++;
      end
      chk(name, LOADED, 1);
   endtask

   task automatic rd(input string name, input logic [7:0] a, input logic [7:0] exp);
      Read_Address = a;
      #1;
      chk(name, instruction, exp);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
`ifndef LOADER_CHECKSUM_EN
      // Cycle table: basic load 03 A1 B2 C3, release after 4 cycles, ignored RELOAD/RX_VALID, RELOAD while RX_VALID.
      vecs.push_back(mk(0,0,8'h00,0,8'h00, 1,1,0,8'h00,8'h00));
      vecs.push_back(mk(1,1,8'h03,0,8'h00, 1,1,0,8'h00,8'h00));
      vecs.push_back(mk(1,1,8'hA1,1,8'h00, 1,1,0,8'h01,8'h00));
      vecs.push_back(mk(1,1,8'hB2,0,8'h00, 1,1,0,8'h02,8'h00));
      vecs.push_back(mk(1,1,8'hC3,0,8'h00, 0,1,0,8'h03,8'h00));
      vecs.push_back(mk(1,0,8'h00,1,8'h00, 0,1,0,8'h03,8'h00));
      vecs.push_back(mk(1,0,8'h00,0,8'h00, 0,1,0,8'h03,8'h00));
      vecs.push_back(mk(1,0,8'h00,0,8'h00, 0,1,0,8'h03,8'h00));
      vecs.push_back(mk(1,0,8'h00,0,8'h00, 0,0,1,8'h03,8'hA1));
      vecs.push_back(mk(1,0,8'h00,0,8'h01, 0,0,1,8'h03,8'hB2));
      vecs.push_back(mk(1,0,8'h00,0,8'h02, 0,0,1,8'h03,8'hC3));
      vecs.push_back(mk(1,0,8'h00,0,8'h03, 0,0,1,8'h03,8'h00));
      vecs.push_back(mk(1,0,8'h00,0,8'hFF, 0,0,1,8'h03,8'h00));
      vecs.push_back(mk(1,1,8'h55,0,8'h00, 0,0,1,8'h03,8'hA1));
      vecs.push_back(mk(1,1,8'h02,1,8'h00, 1,1,0,8'h00,8'h00));
      vecs.push_back(mk(1,0,8'h00,0,8'h00, 1,1,0,8'h00,8'h00));
      vecs.push_back(mk(1,1,8'h01,0,8'h00, 1,1,0,8'h00,8'h00));
      vecs.push_back(mk(1,1,8'h99,0,8'h00, 0,1,0,8'h01,8'h00));
      vecs.push_back(mk(1,0,8'h00,0,8'h00, 0,1,0,8'h01,8'h00));
      vecs.push_back(mk(1,0,8'h00,0,8'h00, 0,1,0,8'h01,8'h00));
      vecs.push_back(mk(1,0,8'h00,0,8'h00, 0,1,0,8'h01,8'h00));
      vecs.push_back(mk(1,0,8'h00,0,8'h00, 0,0,1,8'h01,8'h99));
      vecs.push_back(mk(1,0,8'h00,0,8'h01, 0,0,1,8'h01,8'h00));
      for (int i = 0; i < vecs.size(); i++) begin
         RST = vecs[i].rst_n; RX_VALID = vecs[i].valid; RX_DATA = vecs[i].data;
         RELOAD = vecs[i].reload; Read_Address = vecs[i].addr;
         tick();
         chk($sformatf("v%0d rdy", i), RX_READY, vecs[i].e_rdy);
         chk($sformatf("v%0d cpu_rst", i), CPU_RST, vecs[i].e_cpu);
         chk($sformatf("v%0d loaded", i), LOADED, vecs[i].e_ld);
         chk($sformatf("v%0d count", i), LOAD_COUNT, vecs[i].e_cnt);
         chk($sformatf("v%0d instr", i), instruction, vecs[i].e_ins);
         chk($sformatf("v%0d err", i), ERR, 0);
      end
      RX_VALID = 1'b0; RELOAD = 1'b0;
`endif

      // Full-depth load: length 00, byte i at address i.
      do_reset();
      chk("full rst_cnt", LOAD_COUNT, 0);
      send_len(8'h00);
      for (int i = 0; i < 256; i++) send_data(8'(i));
      chk("full cnt_wrap", LOAD_COUNT, 0);
`ifdef LOADER_CHECKSUM_EN
      chk("full rdy_chk", RX_READY, 1);
      send_tail();
`endif
      chk("full rdy_after", RX_READY, 0);
      wait_loaded("full loaded");
      rd("full rd_ff", 8'hFF, 8'hFF);
      rd("full rd_80", 8'h80, 8'h80);
      rd("full rd_00", 8'h00, 8'h00);

      // Gaps in RX_VALID with garbage on RX_DATA.
      do_reset();
      send_len(8'h03);
      send_data(8'h11);
      repeat (5) tick();
      chk("gap cnt1", LOAD_COUNT, 1);
      send_data(8'h22);
      repeat (5) tick();
      chk("gap cnt2", LOAD_COUNT, 2);
      send_data(8'h33);
      send_tail();
      wait_loaded("gap loaded");
      chk("gap cnt3", LOAD_COUNT, 3);
      rd("gap rd0", 8'h00, 8'h11);
      rd("gap rd1", 8'h01, 8'h22);
      rd("gap rd2", 8'h02, 8'h33);
      rd("gap rd3", 8'h03, 8'h00);

      // Reset mid-load aborts, then a fresh one-byte load.
      do_reset();
      send_len(8'h05);
      send_data(8'hAA);
      send_data(8'hBB);
      RST = 1'b0;
      tick();
      RST = 1'b1;
      chk("mid rdy", RX_READY, 1);
      chk("mid cpu_rst", CPU_RST, 1);
      chk("mid loaded", LOADED, 0);
      chk("mid cnt", LOAD_COUNT, 0);
      rd("mid rd0", 8'h00, 8'h00);
      send_len(8'h01);
      send_data(8'h7E);
      send_tail();
      wait_loaded("mid loaded2");
      rd("mid rd7e", 8'h00, 8'h7E);
      rd("mid rd1", 8'h01, 8'h00);

`ifdef LOADER_CHECKSUM_EN
      // Good checksum releases the CPU; bad checksum latches ERR.
      do_reset();
      send_len(8'h02);
      send_data(8'h0F);
      send_data(8'hF0);
      send_byte(8'hFF);
      wait_loaded("cks good");
      chk("cks err0", ERR, 0);
      RELOAD = 1'b1;
      tick();
      RELOAD = 1'b0;
      send_byte(8'h02);
      send_byte(8'h0F);
      send_byte(8'hF0);
      send_byte(8'h00);
      chk("cks err1", ERR, 1);
      RX_VALID = 1'b1; RX_DATA = 8'h02;
      repeat (6) tick();
      RX_VALID = 1'b0;
      chk("cks err_hold", ERR, 1);
      chk("cks cpu_rst", CPU_RST, 1);
      chk("cks rdy0", RX_READY, 0);
      chk("cks loaded0", LOADED, 0);
      RELOAD = 1'b1;
      tick();
      RELOAD = 1'b0;
      chk("cks rdy_reload", RX_READY, 1);
      chk("cks err_clr", ERR, 0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Writable instruction memory plus a byte-stream program loader. It is the write-side counterpart to the read-only instruction fetch path (PC -> instruction).
- Accepts a length-prefixed program over a valid/ready byte stream and stores it from address 0.
- Holds the Microprocessor in reset until loading completes, then serves combinational instruction reads on Read_Address/instruction.

Parameters:
- ADDR_W, 8, address width; memory depth is 2**ADDR_W.
- DATA_W, 8, instruction/byte width.
- HOLD_CYCLES, 4, cycles CPU_RST stays high after the last accepted byte; range 1..255.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RST  in  1  synchronous, active-low reset (RST=0 sampled at CLK rising edge resets).
- RX_DATA  in  DATA_W  incoming program byte.
- RX_VALID  in  1  RX_DATA valid.
- RX_READY  out  1  loader can accept a byte; a transfer occurs on a CLK edge with RX_VALID&&RX_READY.
- RELOAD  in  1  single-cycle request to reload; honoured only in S_RUN or S_ERR.
- Read_Address  in  ADDR_W  fetch address (driven by PC).
- instruction  out  DATA_W  combinational fetch data.
- CPU_RST  out  1  active-high reset to the Microprocessor.
- LOADED  out  1  program resident, CPU released.
- ERR  out  1  load error latched.
- LOAD_COUNT  out  ADDR_W  payload bytes written so far.

Behaviour:
- Reset (RST=0): state=S_LEN, CPU_RST=1, LOADED=0, ERR=0, LOAD_COUNT=0, RX_READY=1 from the first cycle after reset, len register=0. Memory contents are not cleared.
- S_LEN:
  - First accepted byte is length L. L=0 means 2**ADDR_W bytes.
  - Store L, clear LOAD_COUNT, go to S_DATA.
- S_DATA:
  - Each accepted byte is written to mem[LOAD_COUNT], then LOAD_COUNT increments (wraps mod 2**ADDR_W).
  - After the L-th byte, go to S_CHK if LOADER_CHECKSUM_EN, else S_HOLD.
  - LOAD_COUNT holds its final value; for L=0 it wraps to 0.
- S_HOLD:
  - RX_READY=0; hold counter counts HOLD_CYCLES.
  - Then go to S_RUN with CPU_RST=0 and LOADED=1, both registered.
  - Total cycles from the last-byte edge to CPU_RST falling = HOLD_CYCLES.
- S_RUN:
  - RX_READY=0; RX_VALID is ignored.
  - RELOAD=1 -> next cycle: S_LEN, CPU_RST=1, LOADED=0, ERR=0, LOAD_COUNT=0.
- S_ERR:
  - CPU_RST=1, ERR=1, RX_READY=0.
  - Leave only via RELOAD (same as in S_RUN) or reset.
- RX_READY is 1 in S_LEN, S_DATA and S_CHK; 0 elsewhere. RX_VALID with RX_READY=0 has no effect.
- instruction:
  - 0 when LOADED=0.
  - Otherwise mem[Read_Address] if Read_Address < L (all addresses valid when L=0), else 0.
  - Zero latency, purely combinational from Read_Address.
- Boundary cases:
  - Reset mid-load aborts the load; the partially written memory stays unreadable because LOADED=0.
  - RELOAD in S_LEN, S_DATA, S_CHK or S_HOLD is ignored.
  - Simultaneous RELOAD and RX_VALID in S_RUN: RELOAD wins; the byte is not accepted (RX_READY was 0).

Optional Feature:
- Macro: LOADER_CHECKSUM_EN.
- Defined:
  - A running XOR of payload bytes is kept (cleared in S_LEN).
  - After the payload, S_CHK accepts one checksum byte.
  - Match -> S_HOLD. Mismatch -> S_ERR.
- Undefined: no S_CHK, no XOR register; ERR is tied to 0 and S_ERR is unreachable.

Decomposition:
- Shared package loader_pkg:
  - state encoding: S_LEN, S_DATA, S_CHK, S_HOLD, S_RUN, S_ERR (3-bit);
  - default widths ADDR_W=8, DATA_W=8.
- Sub-module imem_ram:
  - 2**ADDR_W x DATA_W storage;
  - synchronous write port (we, waddr, wdata);
  - asynchronous read port.
- The loader FSM, counters and read gating stay in imem_loader.

Test Plan:
- Basic load: after reset, send 03, A1, B2, C3 (checksum off). Check:
  - CPU_RST falls exactly 4 cycles after C3 is accepted, and LOADED=1;
  - addresses 0/1/2 read A1/B2/C3;
  - address 3 reads 00;
  - LOAD_COUNT=3.
- Full-depth load: length 00 followed by 256 bytes of value i at index i. Check:
  - address FF reads FF;
  - LOAD_COUNT wraps to 00;
  - RX_READY=0 after the 256th byte.
- Gaps in RX_VALID: drop RX_VALID for 5 cycles between bytes. Check that no spurious writes occur and the final contents match.
- Reset mid-load: pull RST low after 2 of 5 bytes. Check:
  - state returns to S_LEN, LOADED=0, instruction=00;
  - a fresh load 01, 7E then reads 7E at address 0.
- RELOAD: in S_RUN, pulse RELOAD while RX_VALID=1. Check:
  - next cycle CPU_RST=1, LOADED=0, RX_READY=1;
  - the byte present with RELOAD is not consumed.
- With LOADER_CHECKSUM_EN defined: send 02, 0F, F0, FF. Check that the checksum matches and the CPU is released. Then after RELOAD send 02, 0F, F0, 00. Check:
  - ERR=1 and CPU_RST stays 1;
  - RX_READY=0 until the next RELOAD.
